// File: rtl/mult_issue_ctrl.sv
// Issue controller for a fixed-latency multiply-add core: registers operands,
// tracks in-flight tags and buffers products in an in-order credit-based FIFO.
module mult_issue_ctrl #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 4,
   localparam int OW     = $clog2(DEPTH + 1)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           io_req_valid,
   output logic           io_req_ready,
   input  logic [52:0]    io_req_a,
   input  logic [52:0]    io_req_b,
   input  logic [52:0]    io_req_c,
   input  logic           io_req_sub,
   input  logic [1:0]     io_req_down,
   input  logic [3:0]     io_req_tag,
   output logic [52:0]    io_multiplicand,
   output logic [52:0]    io_multiplier,
   output logic [52:0]    io_addend,
   output logic           io_sub_vld,
   output logic           io_down_0,
   output logic           io_down_1,
   input  logic [105:0]   io_product,
   output logic           io_resp_valid,
   input  logic           io_resp_ready,
   output logic [105:0]   io_resp_product,
   output logic [3:0]     io_resp_tag,
   output logic [OW-1:0]  io_outstanding
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [OW-1:0] OUT_FULL = OW'(DEPTH);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   logic            req_ready_r;
   logic [OW-1:0]   outstanding_r, outstanding_nxt_s;
   logic            accept_s, pop_s, cap_s;
   logic [LATENCY:0] trk_vld_r;
   logic [3:0]      trk_tag_r [LATENCY+1];
   logic [105:0]    mem_product_r [DEPTH];
   logic [3:0]      mem_tag_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic [OW-1:0]   fifo_cnt_r, fifo_cnt_nxt_s;
   logic            resp_valid_r;
   logic [105:0]    resp_product_r, head_product_s;
   logic [3:0]      resp_tag_r, head_tag_s;
   logic [52:0]     multiplicand_r, multiplier_r, addend_r;
   logic            sub_vld_r, down_0_r, down_1_r;

   assign accept_s = io_req_valid & req_ready_r;
   assign pop_s    = resp_valid_r & io_resp_ready;
   assign cap_s    = trk_vld_r[LATENCY];

   // Next-state for credits, FIFO pointers/occupancy and the head registers.
   always_comb begin
      outstanding_nxt_s = outstanding_r;
      fifo_cnt_nxt_s    = fifo_cnt_r;
      wr_ptr_nxt_s      = wr_ptr_r;
      rd_ptr_nxt_s      = rd_ptr_r;
      head_product_s    = '0;
      head_tag_s        = 4'h0;
      if (accept_s && !pop_s) begin
         outstanding_nxt_s = outstanding_r + OW'(1);
      end else if (!accept_s && pop_s) begin
         outstanding_nxt_s = outstanding_r - OW'(1);
      end else begin
         outstanding_nxt_s = outstanding_r;
      end
      if (cap_s && !pop_s) begin
         fifo_cnt_nxt_s = fifo_cnt_r + OW'(1);
      end else if (!cap_s && pop_s) begin
         fifo_cnt_nxt_s = fifo_cnt_r - OW'(1);
      end else begin
         fifo_cnt_nxt_s = fifo_cnt_r;
      end
      if (cap_s) begin
         wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      // A capture landing in the next head slot bypasses the memory.
      if (cap_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_product_s = io_product;
         head_tag_s     = trk_tag_r[LATENCY];
      end else begin
         head_product_s = mem_product_r[rd_ptr_nxt_s];
         head_tag_s     = mem_tag_r[rd_ptr_nxt_s];
      end
   end

   // Credit counter, ready flag and operand/control registers to the core.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outstanding_r  <= '0;
         req_ready_r    <= 1'b0;
         multiplicand_r <= 53'd0;
         multiplier_r   <= 53'd0;
         addend_r       <= 53'd0;
         sub_vld_r      <= 1'b0;
         down_0_r       <= 1'b0;
         down_1_r       <= 1'b0;
      end else begin
         outstanding_r <= outstanding_nxt_s;
         req_ready_r   <= (outstanding_nxt_s < OUT_FULL);
         if (accept_s) begin
            multiplicand_r <= io_req_a;
            multiplier_r   <= io_req_b;
            addend_r       <= io_req_c;
            sub_vld_r      <= io_req_sub;
            down_0_r       <= io_req_down[0];
            down_1_r       <= io_req_down[1];
         end else begin
            multiplicand_r <= multiplicand_r;
            multiplier_r   <= multiplier_r;
            addend_r       <= addend_r;
            sub_vld_r      <= sub_vld_r;
            down_0_r       <= down_0_r;
            down_1_r       <= down_1_r;
         end
      end
   end

   // Free-running valid/tag tracker mirroring the core pipeline.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trk_vld_r <= '0;
         for (int i = 0; i <= LATENCY; i++) begin
            trk_tag_r[i] <= 4'h0;
         end
      end else begin
         trk_vld_r    <= {trk_vld_r[LATENCY-1:0], accept_s};
         trk_tag_r[0] <= io_req_tag;
         for (int i = 1; i <= LATENCY; i++) begin
            trk_tag_r[i] <= trk_tag_r[i-1];
         end
      end
   end

   // Result FIFO storage, pointers and registered head.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_product_r[i] <= '0;
            mem_tag_r[i]     <= 4'h0;
         end
         wr_ptr_r       <= '0;
         rd_ptr_r       <= '0;
         fifo_cnt_r     <= '0;
         resp_valid_r   <= 1'b0;
         resp_product_r <= '0;
         resp_tag_r     <= 4'h0;
      end else begin
         if (cap_s) begin
            mem_product_r[wr_ptr_r] <= io_product;
            mem_tag_r[wr_ptr_r]     <= trk_tag_r[LATENCY];
         end else begin
            mem_product_r[wr_ptr_r] <= mem_product_r[wr_ptr_r];
            mem_tag_r[wr_ptr_r]     <= mem_tag_r[wr_ptr_r];
         end
         wr_ptr_r       <= wr_ptr_nxt_s;
         rd_ptr_r       <= rd_ptr_nxt_s;
         fifo_cnt_r     <= fifo_cnt_nxt_s;
         resp_valid_r   <= (fifo_cnt_nxt_s != '0);
         resp_product_r <= head_product_s;
         resp_tag_r     <= head_tag_s;
      end
   end

   assign io_req_ready    = req_ready_r;
   assign io_outstanding  = outstanding_r;
   assign io_multiplicand = multiplicand_r;
   assign io_multiplier   = multiplier_r;
   assign io_addend       = addend_r;
   assign io_sub_vld      = sub_vld_r;
   assign io_down_0       = down_0_r;
   assign io_down_1       = down_1_r;
   assign io_resp_valid   = resp_valid_r;
   assign io_resp_product = resp_product_r;
   assign io_resp_tag     = resp_tag_r;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl with a 4-cycle registered A*B+/-C core model.
module tb_mult_issue_ctrl;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          io_req_valid = 1'b0;
   logic          io_req_ready;
   logic [52:0]   io_req_a = 53'd0, io_req_b = 53'd0, io_req_c = 53'd0;
   logic          io_req_sub = 1'b0;
   logic [1:0]    io_req_down = 2'b00;
   logic [3:0]    io_req_tag = 4'h0;
   logic [52:0]   io_multiplicand, io_multiplier, io_addend;
   logic          io_sub_vld, io_down_0, io_down_1;
   logic [105:0]  io_product;
   logic          io_resp_valid;
   logic          io_resp_ready = 1'b0;
   logic [105:0]  io_resp_product;
   logic [3:0]    io_resp_tag;
   logic [2:0]    io_outstanding;

   int tests = 0;
   int fails = 0;
   int late_valid = 0;
   logic [109:0] sb_q [$];

   mult_issue_ctrl #(.LATENCY(4), .DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
      .io_req_a(io_req_a), .io_req_b(io_req_b), .io_req_c(io_req_c),
      .io_req_sub(io_req_sub), .io_req_down(io_req_down), .io_req_tag(io_req_tag),
      .io_multiplicand(io_multiplicand), .io_multiplier(io_multiplier), .io_addend(io_addend),
      .io_sub_vld(io_sub_vld), .io_down_0(io_down_0), .io_down_1(io_down_1),
      .io_product(io_product),
      .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
      .io_resp_product(io_resp_product), .io_resp_tag(io_resp_tag),
      .io_outstanding(io_outstanding)
   );

   always #5 clock = ~clock;

   // Core model: four registered stages after the operand registers.
   logic [105:0] core_p [4];
   logic [105:0] core_mul;
   assign core_mul   = {53'd0, io_multiplicand} * {53'd0, io_multiplier};
   assign io_product = core_p[3];
   always @(posedge clock) begin
      core_p[0] <= io_sub_vld ? core_mul - {53'd0, io_addend} : core_mul + {53'd0, io_addend};
      core_p[1] <= core_p[0];
      core_p[2] <= core_p[1];
      core_p[3] <= core_p[2];
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare each handshaken result against the scoreboard head.
   always @(negedge clock) begin
      if (reset && io_resp_valid && io_resp_ready) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            late_valid++;
            $display("FAIL unexpected_resp: got tag %0h product %0h expected none", io_resp_tag, io_resp_product);
         end else begin
            logic [109:0] e;
            e = sb_q.pop_front();
            check("resp_tag", {124'd0, io_resp_tag}, {124'd0, e[109:106]});
            check("resp_product", {22'd0, io_resp_product}, {22'd0, e[105:0]});
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [52:0] a, input logic [52:0] b, input logic [52:0] c,
                        input logic sub, input logic [1:0] down, input logic [3:0] tag);
      io_req_valid = 1'b1;
      io_req_a = a; io_req_b = b; io_req_c = c;
      io_req_sub = sub; io_req_down = down; io_req_tag = tag;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   logic [105:0] exp_t3 [5] = '{106'd2, 106'd4, 106'd6, 106'd8, 106'd10};
   logic [105:0] max_prod;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      io_resp_ready = 1'b1;
      idle(2);
      check("rst_ready", {127'd0, io_req_ready}, 128'd0);
      check("rst_resp_valid", {127'd0, io_resp_valid}, 128'd0);
      check("rst_outstanding", {125'd0, io_outstanding}, 128'd0);
      check("rst_multiplicand", {75'd0, io_multiplicand}, 128'd0);
      reset = 1'b1;
      step();
      check("ready_after_rst", {127'd0, io_req_ready}, 128'd1);

      // A*B+C = 3*5+7 = 22, tag 1
      drive(53'd3, 53'd5, 53'd7, 1'b0, 2'b00, 4'h1);
      sb_q.push_back({4'h1, 106'd22});
      step();
      io_req_valid = 1'b0;
      check("multiplicand_load", {75'd0, io_multiplicand}, 128'd3);
      check("outstanding_1", {125'd0, io_outstanding}, 128'd1);
      idle(4);
      check("resp_valid_early", {127'd0, io_resp_valid}, 128'd0);
      step();
      check("resp_valid_edge5", {127'd0, io_resp_valid}, 128'd1);
      idle(2);
      check("outstanding_drain", {125'd0, io_outstanding}, 128'd0);

      // A*B-C = 15-7 = 8, tag 2, down 2'b10
      drive(53'd3, 53'd5, 53'd7, 1'b1, 2'b10, 4'h2);
      sb_q.push_back({4'h2, 106'd8});
      step();
      io_req_valid = 1'b0;
      check("down_bits", {126'd0, io_down_1, io_down_0}, 128'd2);
      check("sub_vld", {127'd0, io_sub_vld}, 128'd1);
      idle(8);

      // Fill credits with consumer stalled; tag i product = (i+1)*2
      io_resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(53'(i + 1), 53'd2, 53'd0, 1'b0, 2'b00, 4'(i));
         check("b2b_ready", {127'd0, io_req_ready}, 128'd1);
         sb_q.push_back({4'(i), exp_t3[i]});
         step();
      end
      drive(53'd5, 53'd2, 53'd0, 1'b0, 2'b00, 4'h4);
      check("full_ready", {127'd0, io_req_ready}, 128'd0);
      check("full_outstanding", {125'd0, io_outstanding}, 128'd4);
      idle(8);
      check("held_ready", {127'd0, io_req_ready}, 128'd0);
      check("held_outstanding", {125'd0, io_outstanding}, 128'd4);
      check("full_head_valid", {127'd0, io_resp_valid}, 128'd1);
      check("full_head_tag", {124'd0, io_resp_tag}, 128'd0);
      io_resp_ready = 1'b1;
      step();
      check("first_pop_outstanding", {125'd0, io_outstanding}, 128'd3);
      check("first_pop_ready", {127'd0, io_req_ready}, 128'd1);
      sb_q.push_back({4'h4, exp_t3[4]});
      step();
      io_req_valid = 1'b0;
      check("pop_accept_outstanding", {125'd0, io_outstanding}, 128'd3);
      idle(12);
      check("t3_drained", {125'd0, io_outstanding}, 128'd0);

      // (2^53-1)^2 + (2^53-1) = 2^106 - 2^53
      max_prod = {53'h1FFFFFFFFFFFFF, 53'd0};
      drive(53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, 1'b0, 2'b01, 4'h5);
      sb_q.push_back({4'h5, max_prod});
      step();
      io_req_valid = 1'b0;
      idle(8);

      // Reset two cycles after an accept drops the request
      drive(53'd9, 53'd9, 53'd1, 1'b0, 2'b00, 4'h6);
      step();
      io_req_valid = 1'b0;
      idle(2);
      reset = 1'b0;
      #1;
      check("mid_rst_multiplicand", {75'd0, io_multiplicand}, 128'd0);
      check("mid_rst_outstanding", {125'd0, io_outstanding}, 128'd0);
      check("mid_rst_ready", {127'd0, io_req_ready}, 128'd0);
      check("mid_rst_resp", {21'd0, io_resp_valid, io_resp_product}, 128'd0);
      check("mid_rst_tag", {124'd0, io_resp_tag}, 128'd0);
      idle(2);
      reset = 1'b1;
      step();
      check("post_rst_ready", {127'd0, io_req_ready}, 128'd1);
      idle(10);
      check("no_late_resp", 128'(late_valid), 128'd0);
      check("scoreboard_empty", 128'(sb_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
